// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: miss-FSM state
// encodings and the stall/flush vector bit positions.
package pipe_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    I_IDLE = 2'd0,
    I_MISS = 2'd1,
    I_DROP = 2'd2
  } i_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_MISS = 1'b1
  } d_state_t;

  // Positions in fc_stall_o / fc_flush_o: bit 0 is the PC, bit k is the
  // register between stage k-1 and stage k.
  localparam int IDX_PC   = 0;
  localparam int IDX_IFID = 1;
  localparam int IDX_IDEX = 2;

endpackage

// File: rtl/pipe_flow_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; stops at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count enabled events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: merges redirect, load-use and cache-miss
// hazards into per-boundary stall/flush vectors, defers a redirect that
// arrives during an I-cache refill until the refill completes, and keeps
// stall-cycle and redirect counters.
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_jump_flag_i,
  input  logic [XLEN-1:0]   id_jump_pc_i,
  input  logic              ex_branch_flag_i,
  input  logic [XLEN-1:0]   ex_branch_pc_i,
  input  logic              id_load_use_flag_i,
  input  logic              if_req_icache_i,
  input  logic              icache_hit_i,
  input  logic              rom_ready_i,
  input  logic              ex_req_dcache_i,
  input  logic              dcache_hit_i,
  input  logic              ram_ready_i,
  output logic [NSTAGE-1:0] fc_stall_o,
  output logic [NSTAGE-1:0] fc_flush_o,
  output logic              fc_jump_flag_o,
  output logic [XLEN-1:0]   fc_jump_pc_o,
  output logic              fc_icache_busy_o,
  output logic              fc_dcache_busy_o,
  output logic [CNT_W-1:0]  fc_stall_cnt_o,
  output logic [CNT_W-1:0]  fc_redir_cnt_o
);

  i_state_t        i_state, i_next;
  d_state_t        d_state, d_next;
  logic [XLEN-1:0] pend_pc, pend_next;

  logic            redir_req, redir_eff;
  logic [XLEN-1:0] redir_pc;
  logic            i_miss_now, d_miss_now;
  logic            i_busy, d_busy;
  logic            enter_drop, drop_release;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;

  // EX is older than ID, so its branch wins and supplies the target.
  assign redir_req  = ex_branch_flag_i | id_jump_flag_i;
  assign redir_pc   = ex_branch_flag_i ? ex_branch_pc_i : id_jump_pc_i;
  assign i_miss_now = if_req_icache_i & ~icache_hit_i;
  assign d_miss_now = ex_req_dcache_i & ~dcache_hit_i;
  assign i_busy     = (i_state != I_IDLE) | i_miss_now;
  assign d_busy     = (d_state == D_MISS) | d_miss_now;
  // A D-cache stall freezes the whole pipe, so the redirect source stays
  // put and re-presents its flag once the refill is done.
  assign redir_eff  = redir_req & ~d_busy;

  // I-FSM next state and pending-target capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path
    // leaves it unassigned, which would infer a latch.
    i_next       = i_state;
    pend_next    = pend_pc;
    enter_drop   = 1'b0;
    drop_release = 1'b0;
    case (i_state)
      I_IDLE: begin
        if (i_miss_now) i_next = I_MISS;
      end
      I_MISS: begin
        if (rom_ready_i) begin
          i_next = I_IDLE;
        end else if (redir_eff) begin
          i_next     = I_DROP;
          pend_next  = redir_pc;
          enter_drop = 1'b1;
        end
      end
      I_DROP: begin
        if (redir_eff) pend_next = redir_pc;
        if (rom_ready_i) begin
          i_next       = I_IDLE;
          drop_release = 1'b1;
        end
      end
      default: i_next = I_IDLE;
    endcase
  end

  // D-FSM next state.
  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:  if (d_miss_now) d_next = D_MISS;
      D_MISS:  if (ram_ready_i) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_state <= I_IDLE;
      d_state <= D_IDLE;
      pend_pc <= '0;
    end else begin
      i_state <= i_next;
      d_state <= d_next;
      pend_pc <= pend_next;
    end
  end

  // Zero-latency stall, flush and redirect outputs; all forced low in reset.
  always_comb begin
    fc_stall_o       = '0;
    fc_flush_o       = '0;
    fc_jump_flag_o   = 1'b0;
    fc_jump_pc_o     = '0;
    fc_icache_busy_o = 1'b0;
    fc_dcache_busy_o = 1'b0;
    if (!rst) begin
      fc_icache_busy_o = i_busy;
      fc_dcache_busy_o = d_busy;
      if (d_busy) begin
        fc_stall_o = '1;
      end else begin
        if (i_busy || id_load_use_flag_i) begin
          fc_stall_o[IDX_PC]   = 1'b1;
          fc_stall_o[IDX_IFID] = 1'b1;
        end
        fc_flush_o[IDX_IFID] = redir_req;
        fc_flush_o[IDX_IDEX] = ex_branch_flag_i | id_load_use_flag_i;
        if (drop_release) begin
          // A redirect coinciding with the refill end is newer than the
          // parked one, so it is the target that goes out.
          fc_jump_flag_o = 1'b1;
          fc_jump_pc_o   = redir_eff ? redir_pc : pend_pc;
        end else if (redir_eff && (i_state != I_DROP) && !enter_drop) begin
          fc_jump_flag_o = 1'b1;
          fc_jump_pc_o   = redir_pc;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (|fc_stall_o),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fc_jump_flag_o),
    .count (redir_cnt)
  );

  assign fc_stall_cnt_o = rst ? '0 : stall_cnt;
  assign fc_redir_cnt_o = rst ? '0 : redir_cnt;

endmodule
